// File: rtl/ppcpu_pkg.sv
// Shared constants and types for the instruction fetch front end.
package ppcpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10
  } fetch_state_t;

  // One prefetch queue entry: fetch address plus the word returned for it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO of {pc, inst}; flush wins over push and pop.
module if_fifo
  import ppcpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Effective push/pop; a full queue still accepts a push alongside a pop.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch front end: fetch FSM, redirect mux and prefetch queue feeding ID.
module if_prefetch_unit
  import ppcpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst,
  output logic [31:0] PC,
  output logic [31:0] pc4,
  output logic        inst_valid,
  input  logic        id_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t   state, state_d;
  logic [31:0]    fetch_pc, fetch_pc_d;
  logic [31:0]    req_pc, req_pc_d;
  logic           req_en;
  logic           redirect;
  logic [31:0]    target;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  fetch_entry_t   fifo_din;
  fetch_entry_t   fifo_head;

  // Redirect decode and word-aligned target select.
  always_comb begin
    redirect = (pcsource == PCSRC_BR) || (pcsource == PCSRC_JMP);
    target   = ((pcsource == PCSRC_BR) ? bpc : jpc) & 32'hFFFF_FFFC;
  end

  // State, fetch address and outstanding-request address; req_en keeps the
  // request low until the first clock after reset release.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      req_en   <= 1'b0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      req_pc   <= req_pc_d;
      req_en   <= 1'b1;
    end
  end

  // Next state, memory request and queue push; a redirect flushes and retargets.
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    req_pc_d   = req_pc;
    imem_req   = 1'b0;
    fifo_push  = 1'b0;

    case (state)
      FETCH: begin
        imem_req = req_en && (fifo_count < CW'(DEPTH));
        if (imem_req && imem_gnt) begin
          req_pc_d   = fetch_pc;
          fetch_pc_d = fetch_pc + 32'd4;
          state_d    = redirect ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          fifo_push = ~redirect & (~fifo_full | fifo_pop);
          state_d   = FETCH;
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (redirect) fetch_pc_d = target;
  end

  assign imem_addr = fetch_pc;
  assign fifo_pop  = inst_valid & id_ready & ~redirect;
  assign fifo_din  = '{pc: req_pc, inst: imem_rdata};

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clock),
    .rst_n (Resetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head entry presented to ID; NOP and zero PCs when the queue is empty.
  always_comb begin
    inst_valid = ~fifo_empty;
    Inst       = fifo_empty ? INST_NOP : fifo_head.inst;
    PC         = fifo_empty ? 32'h0 : fifo_head.pc;
    pc4        = fifo_empty ? 32'h0 : fifo_head.pc + 32'd4;
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Scoreboard bench for if_prefetch_unit with a variable-latency memory model.
module tb_if_prefetch_unit;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'h0;
  logic [31:0] jpc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Inst;
  logic [31:0] PC;
  logic [31:0] pc4;
  logic        inst_valid;
  logic        id_ready = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  int          grants_allowed = 0;
  int          grants_done    = 0;
  int          lat            = 1;
  logic        gnt_seen       = 1'b0;
  logic [31:0] gnt_addr       = 32'h0;
  logic        pend           = 1'b0;
  int          pend_cnt       = 0;
  logic [31:0] pend_addr      = 32'h0;

  always #5 Clock = ~Clock;

  if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .jpc         (jpc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Inst        (Inst),
    .PC          (PC),
    .pc4         (pc4),
    .inst_valid  (inst_valid),
    .id_ready    (id_ready)
  );

  // Memory grants only while the bench has budget left.
  assign imem_gnt = imem_req && (grants_done < grants_allowed);

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {16'hC0DE ^ a[31:16], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] pc_plus4);
    exp_t e;
    e.pc   = pc;
    e.inst = word_of(pc);
    e.pc4  = pc_plus4;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_grant(input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge Clock);
      if (imem_req && imem_gnt) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic wait_req_addr(input string name, input logic [31:0] exp_addr);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge Clock);
      if (imem_req) got = 1'b1;
    end
    check(name, got ? imem_addr : 32'hDEAD_BEEF, exp_addr);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge Clock);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req),   32'd0);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"},  Inst,            32'h0);
    check({tag, "_pc"},    PC,              32'h0);
    check({tag, "_pc4"},   pc4,             32'h0);
  endtask

  // Record a grant as seen mid-cycle; it takes effect at the next rising edge.
  always @(negedge Clock) begin
    gnt_seen = imem_req && imem_gnt;
    gnt_addr = imem_addr;
  end

  // Memory response: rvalid lat cycles after the grant cycle. A pending
  // response survives reset so the DUT has to ignore it.
  always @(posedge Clock) begin
    #1;
    imem_rvalid = 1'b0;
    if (gnt_seen) begin
      grants_done++;
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = gnt_addr;
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  end

  // Monitor: every accepted head is compared with the oldest expectation.
  always @(negedge Clock) begin
    if (Resetn && inst_valid && id_ready && !(pcsource == 2'b01 || pcsource == 2'b10)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pop: got pc %h inst %h expected no entry", PC, Inst);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_pc",   PC,   e.pc);
        check("pop_inst", Inst, e.inst);
        check("pop_pc4",  pc4,  e.pc4);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check_reset_outputs("reset");

    // 1: straight-line fetch with a 1-cycle memory
    id_ready = 1'b1;
    lat = 1;
    grants_allowed += 4;
    expect_entry(32'h0, 32'h4);
    expect_entry(32'h4, 32'h8);
    expect_entry(32'h8, 32'hC);
    expect_entry(32'hC, 32'h10);
    tick();
    Resetn = 1'b1;
    wait_drain("t1_drain");

    // 2: ID stalled; queue fills at 4, then drains and fetch resumes at 0x10
    tick();
    Resetn = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
    id_ready = 1'b0;
    begin
      int g0;
      g0 = grants_done;
      grants_allowed += 5;
      repeat (10) tick();
      check("t2_grants", 32'(grants_done - g0), 32'd4);
    end
    @(negedge Clock);
    check("t2_req_stalled", 32'(imem_req),   32'd0);
    check("t2_valid",       32'(inst_valid), 32'd1);
    check("t2_head_pc",     PC,              32'h0);
    expect_entry(32'h0,  32'h4);
    expect_entry(32'h4,  32'h8);
    expect_entry(32'h8,  32'hC);
    expect_entry(32'hC,  32'h10);
    expect_entry(32'h10, 32'h14);
    tick();
    id_ready = 1'b1;
    wait_drain("t2_drain");

    // 3: branch while waiting on a slow response; stale word must vanish
    tick();
    lat = 3;
    grants_allowed += 1;
    wait_grant("t3_grant");
    tick();
    pcsource = 2'b01;
    bpc = 32'h103;
    grants_allowed += 1;
    expect_entry(32'h100, 32'h104);
    tick();
    pcsource = 2'b00;
    wait_req_addr("t3_addr", 32'h100);
    wait_drain("t3_drain");

    // 4: jump coinciding with rvalid and a pop of a valid head
    tick();
    id_ready = 1'b0;
    lat = 2;
    grants_allowed += 2;
    wait_grant("t4_grant_a");
    wait_grant("t4_grant_b");
    tick();
    tick();
    pcsource = 2'b10;
    jpc = 32'h200;
    id_ready = 1'b1;
    exp_q.delete();
    grants_allowed += 1;
    expect_entry(32'h200, 32'h204);
    @(negedge Clock);
    check("t4_head_valid", 32'(inst_valid), 32'd1);
    tick();
    pcsource = 2'b00;
    @(negedge Clock);
    check("t4_flushed", 32'(inst_valid), 32'd0);
    check("t4_req",     32'(imem_req),   32'd1);
    check("t4_addr",    imem_addr,       32'h200);
    wait_drain("t4_drain");

    // 5: redirect near the top of the address space; fetch wraps to 0
    tick();
    lat = 1;
    pcsource = 2'b01;
    bpc = 32'hFFFF_FFF8;
    tick();
    pcsource = 2'b00;
    grants_allowed += 3;
    expect_entry(32'hFFFF_FFF8, 32'hFFFF_FFFC);
    expect_entry(32'hFFFF_FFFC, 32'h0);
    expect_entry(32'h0,         32'h4);
    wait_req_addr("t5_addr", 32'hFFFF_FFF8);
    wait_drain("t5_drain");

    // 6: reset while waiting with three entries queued
    tick();
    id_ready = 1'b0;
    lat = 3;
    grants_allowed += 4;
    wait_grant("t6_grant_a");
    wait_grant("t6_grant_b");
    wait_grant("t6_grant_c");
    wait_grant("t6_grant_d");
    check("t6_pre_valid", 32'(inst_valid), 32'd1);
    check("t6_pre_pc",    PC,              32'h4);
    tick();
    Resetn = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("t6_reset");
    tick();
    Resetn = 1'b1;
    id_ready = 1'b1;
    lat = 1;
    grants_allowed += 1;
    expect_entry(32'h0, 32'h4);
    wait_req_addr("t6_first_addr", 32'h0);
    wait_drain("t6_drain");

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
